// File: rtl/cpu_bus_master.sv
// HD6301-style CPU bus initiator: turns valid/ready host requests into E/AS/RW bus cycles with idle dummy reads.
// Optional IRQ synchroniser and sticky pending flag enabled by defining CPU_BUS_IRQ_SYNC_EN.
module cpu_bus_master #(
  parameter int          PHASE_CYCLES = 2,
  parameter logic [15:0] IDLE_ADDR    = 16'hFFFF
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic        REQ_VALID_IN,
  output logic        REQ_READY_OUT,
  input  logic        REQ_RW_IN,
  input  logic [15:0] REQ_ADDR_IN,
  input  logic [7:0]  REQ_WDATA_IN,
  output logic        RSP_VALID_OUT,
  output logic [7:0]  RSP_RDATA_OUT,
  output logic        E_OUT,
  output logic        AS_OUT,
  output logic        RW_OUT,
  output logic [7:0]  CPU_P4_OUT,
  output logic [7:0]  CPU_P3_OUT,
  input  logic [7:0]  CPU_P3_IN,
  output logic        CPU_P3_IOM,
  input  logic        IRQ_IN,
  output logic        IRQ_PEND_OUT,
  input  logic        IRQ_ACK_IN
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {PH_ADDR, PH_LATCH, PH_DATA} phase_t;

  phase_t           phase, phase_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             cyc_real, cyc_real_nx;
  logic             cyc_rw, cyc_rw_nx;
  logic [15:0]      cyc_addr, cyc_addr_nx;
  logic [7:0]       cyc_wdata, cyc_wdata_nx;
  logic             boundary, hs;
  logic             e_nx, as_nx, rw_nx, iom_nx, ready_nx;
  logic [7:0]       p4_nx, p3_nx;

  assign boundary = (phase == PH_DATA) && (cnt == CNT_LAST);
  assign hs       = REQ_VALID_IN && REQ_READY_OUT;

  // Reset parks the position at the end of a DATA phase so the first edge after release opens an idle cycle.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      phase         <= PH_DATA;
      cnt           <= CNT_LAST;
      cyc_real      <= 1'b0;
      E_OUT         <= 1'b0;
      AS_OUT        <= 1'b0;
      RW_OUT        <= 1'b1;
      CPU_P4_OUT    <= 8'h00;
      CPU_P3_OUT    <= 8'h00;
      CPU_P3_IOM    <= 1'b0;
      REQ_READY_OUT <= 1'b0;
      RSP_VALID_OUT <= 1'b0;
      RSP_RDATA_OUT <= 8'h00;
    end else begin
      phase         <= phase_nx;
      cnt           <= cnt_nx;
      cyc_real      <= cyc_real_nx;
      E_OUT         <= e_nx;
      AS_OUT        <= as_nx;
      RW_OUT        <= rw_nx;
      CPU_P4_OUT    <= p4_nx;
      CPU_P3_OUT    <= p3_nx;
      CPU_P3_IOM    <= iom_nx;
      REQ_READY_OUT <= ready_nx;
      RSP_VALID_OUT <= boundary && cyc_real;
      if (boundary && cyc_real)
        RSP_RDATA_OUT <= cyc_rw ? CPU_P3_IN : 8'h00;
    end
  end

  always_ff @(posedge CLK_IN) begin
    cyc_rw    <= cyc_rw_nx;
    cyc_addr  <= cyc_addr_nx;
    cyc_wdata <= cyc_wdata_nx;
  end

  always_comb begin
    phase_nx     = phase;
    cnt_nx       = cnt + 1'b1;
    cyc_real_nx  = cyc_real;
    cyc_rw_nx    = cyc_rw;
    cyc_addr_nx  = cyc_addr;
    cyc_wdata_nx = cyc_wdata;
    if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      case (phase)
        PH_ADDR:  phase_nx = PH_LATCH;
        PH_LATCH: phase_nx = PH_DATA;
        default:  phase_nx = PH_ADDR;
      endcase
    end
    if (boundary) begin
      if (hs) begin
        cyc_real_nx  = 1'b1;
        cyc_rw_nx    = REQ_RW_IN;
        cyc_addr_nx  = REQ_ADDR_IN;
        cyc_wdata_nx = REQ_WDATA_IN;
      end else begin
        cyc_real_nx  = 1'b0;
        cyc_rw_nx    = 1'b1;
        cyc_addr_nx  = IDLE_ADDR;
        cyc_wdata_nx = 8'h00;
      end
    end
  end

  // Pin values are computed for the upcoming position so every output is a flop.
  always_comb begin
    e_nx     = (phase_nx == PH_DATA);
    as_nx    = (phase_nx == PH_ADDR);
    rw_nx    = cyc_rw_nx;
    p4_nx    = cyc_addr_nx[15:8];
    p3_nx    = cyc_addr_nx[7:0];
    iom_nx   = 1'b1;
    ready_nx = (phase_nx == PH_DATA) && (cnt_nx == CNT_LAST);
    if (phase_nx == PH_DATA) begin
      if (cyc_rw_nx) iom_nx = 1'b0;
      else           p3_nx  = cyc_wdata_nx;
    end
  end

`ifdef CPU_BUS_IRQ_SYNC_EN
  logic irq_s1, irq_s2;

  // A synchronised low level re-sets the flag on the same edge an ack would clear it, so set wins.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      irq_s1       <= 1'b1;
      irq_s2       <= 1'b1;
      IRQ_PEND_OUT <= 1'b0;
    end else begin
      irq_s1       <= IRQ_IN;
      irq_s2       <= irq_s1;
      IRQ_PEND_OUT <= !irq_s2 || (IRQ_PEND_OUT && !IRQ_ACK_IN);
    end
  end
`else
  wire unused_irq = IRQ_IN ^ IRQ_ACK_IN;
  assign IRQ_PEND_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: per-clock pin model, request vector table, back-to-back, reset-abort and IRQ sequences.
module tb_cpu_bus_master;

  localparam int PC  = 2;
  localparam int LEN = 3 * PC;

  logic        CLK_IN = 1'b0;
  logic        RST_IN = 1'b0;
  logic        REQ_VALID_IN = 1'b0;
  logic        REQ_READY_OUT;
  logic        REQ_RW_IN = 1'b1;
  logic [15:0] REQ_ADDR_IN = 16'h0;
  logic [7:0]  REQ_WDATA_IN = 8'h0;
  logic        RSP_VALID_OUT;
  logic [7:0]  RSP_RDATA_OUT;
  logic        E_OUT, AS_OUT, RW_OUT;
  logic [7:0]  CPU_P4_OUT, CPU_P3_OUT;
  logic [7:0]  CPU_P3_IN = 8'h0;
  logic        CPU_P3_IOM;
  logic        IRQ_IN = 1'b1;
  logic        IRQ_PEND_OUT;
  logic        IRQ_ACK_IN = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cpu_bus_master #(.PHASE_CYCLES(PC), .IDLE_ADDR(16'hFFFF)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN),
    .REQ_VALID_IN(REQ_VALID_IN), .REQ_READY_OUT(REQ_READY_OUT),
    .REQ_RW_IN(REQ_RW_IN), .REQ_ADDR_IN(REQ_ADDR_IN), .REQ_WDATA_IN(REQ_WDATA_IN),
    .RSP_VALID_OUT(RSP_VALID_OUT), .RSP_RDATA_OUT(RSP_RDATA_OUT),
    .E_OUT(E_OUT), .AS_OUT(AS_OUT), .RW_OUT(RW_OUT),
    .CPU_P4_OUT(CPU_P4_OUT), .CPU_P3_OUT(CPU_P3_OUT), .CPU_P3_IN(CPU_P3_IN),
    .CPU_P3_IOM(CPU_P3_IOM), .IRQ_IN(IRQ_IN), .IRQ_PEND_OUT(IRQ_PEND_OUT),
    .IRQ_ACK_IN(IRQ_ACK_IN)
  );

  always #5 CLK_IN = ~CLK_IN;
  always @(posedge CLK_IN) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s clk=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Reference model: position in the bus cycle is clocks-since-start modulo 3P; each cycle carries
  // the request accepted at the previous cycle's last clock, or an idle read.
  bit          started = 0;
  int          n = 0;
  logic        cur_real, cur_rw;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wd;
  logic        rsp_m = 1'b0;
  logic [7:0]  rdata_m = 8'h0;

  always @(negedge CLK_IN) begin
    logic [29:0] ev, av, mk;
    logic [7:0]  p3e;
    logic        iome;
    int          pos, ph;
    mk = '1;
    if (RST_IN || !started) begin
      ev = {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      if (RST_IN) started = 0;
      else begin
        started = 1; n = 0;
        cur_real = 0; cur_rw = 1; cur_addr = 16'hFFFF; cur_wd = 0;
      end
      rsp_m = 0; rdata_m = 0;
    end else begin
      pos  = n % LEN;
      ph   = pos / PC;
      iome = !(ph == 2 && cur_rw);
      p3e  = (ph == 2 && !cur_rw) ? cur_wd : cur_addr[7:0];
      ev = {ph == 2, ph == 0, cur_rw, cur_addr[15:8], p3e, iome, pos == LEN - 1, rsp_m, rdata_m};
      if (!iome) mk[18:11] = 8'h00;
      if (pos == LEN - 1) begin
        rsp_m = cur_real;
        if (cur_real) rdata_m = cur_rw ? CPU_P3_IN : 8'h00;
        if (REQ_VALID_IN) begin
          cur_real = 1; cur_rw = REQ_RW_IN; cur_addr = REQ_ADDR_IN; cur_wd = REQ_WDATA_IN;
        end else begin
          cur_real = 0; cur_rw = 1; cur_addr = 16'hFFFF; cur_wd = 0;
        end
      end else rsp_m = 0;
      n++;
    end
    av = {E_OUT, AS_OUT, RW_OUT, CPU_P4_OUT, CPU_P3_OUT, CPU_P3_IOM, REQ_READY_OUT, RSP_VALID_OUT, RSP_RDATA_OUT};
    checks++;
    if ((av & mk) !== (ev & mk)) begin
      failures++;
      $display("FAIL bus_pins clk=%0d got=%h want=%h", cyc, av & mk, ev & mk);
    end
  end

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  p3;
    logic [7:0]  exp_rdata;
  } vec_t;

  task automatic do_req(input vec_t v);
    bit got;
    bit rsp;
    int lat;
    @(posedge CLK_IN); #1;
    REQ_VALID_IN = 1; REQ_RW_IN = v.rw; REQ_ADDR_IN = v.addr; REQ_WDATA_IN = v.wdata;
    CPU_P3_IN = v.p3;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK_IN);
      if (REQ_READY_OUT) got = 1;
    end
    @(posedge CLK_IN); #1;
    REQ_VALID_IN = 0;
    REQ_ADDR_IN = 16'($urandom); REQ_WDATA_IN = 8'($urandom); REQ_RW_IN = 1'($urandom);
    check("handshake", {31'b0, got}, 32'd1);
    rsp = 0; lat = 0;
    for (int i = 1; i <= 20 && !rsp; i++) begin
      @(negedge CLK_IN);
      if (RSP_VALID_OUT) begin rsp = 1; lat = i; end
    end
    check("rsp_latency", lat, 32'd7);
    check("rsp_rdata", {24'b0, RSP_RDATA_OUT}, {24'b0, v.exp_rdata});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog clk=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   ecnt, acnt, nhs, nrsp, quiet;
    int   hs_t[3], rsp_t[3];
    bit   hs_now, seen_e;

    vecs[0] = '{rw: 1'b0, addr: 16'h1005, wdata: 8'h5A, p3: 8'h11, exp_rdata: 8'h00};
    vecs[1] = '{rw: 1'b1, addr: 16'hC000, wdata: 8'h00, p3: 8'hA7, exp_rdata: 8'hA7};
    vecs[2] = '{rw: 1'b0, addr: 16'h0000, wdata: 8'hFF, p3: 8'hEE, exp_rdata: 8'h00};
    vecs[3] = '{rw: 1'b1, addr: 16'hFFFF, wdata: 8'h12, p3: 8'h00, exp_rdata: 8'h00};
    vecs[4] = '{rw: 1'b1, addr: 16'h8181, wdata: 8'h34, p3: 8'h3C, exp_rdata: 8'h3C};

    #2 RST_IN = 1;
    repeat (3) @(posedge CLK_IN);
    #1 RST_IN = 0;

    // Idle running: any 12-clock window holds two E-high and two AS-high pulses of P clocks.
    repeat (4) @(posedge CLK_IN);
    ecnt = 0; acnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_IN);
      ecnt += int'(E_OUT);
      acnt += int'(AS_OUT);
    end
    check("idle_e_high", ecnt, 32'd4);
    check("idle_as_high", acnt, 32'd4);

    for (int i = 0; i < 5; i++) do_req(vecs[i]);

    // Continuous VALID for three reads.
    @(posedge CLK_IN); #1;
    REQ_VALID_IN = 1; REQ_RW_IN = 1; REQ_ADDR_IN = 16'h2000; CPU_P3_IN = 8'h30;
    nhs = 0; nrsp = 0;
    for (int i = 0; i < 60 && nrsp < 3; i++) begin
      @(negedge CLK_IN);
      hs_now = REQ_READY_OUT && REQ_VALID_IN;
      if (RSP_VALID_OUT) begin rsp_t[nrsp] = cyc; nrsp++; end
      if (hs_now) begin hs_t[nhs] = cyc; nhs++; end
      @(posedge CLK_IN); #1;
      if (hs_now) begin
        if (nhs == 3) REQ_VALID_IN = 0;
        else REQ_ADDR_IN = REQ_ADDR_IN + 16'h1;
      end
    end
    check("b2b_handshakes", nhs, 32'd3);
    check("b2b_responses", nrsp, 32'd3);
    if (nhs == 3 && nrsp == 3) begin
      check("b2b_hs_gap1", hs_t[1] - hs_t[0], 32'd6);
      check("b2b_hs_gap2", hs_t[2] - hs_t[1], 32'd6);
      check("b2b_rsp_gap1", rsp_t[1] - rsp_t[0], 32'd6);
      check("b2b_rsp_gap2", rsp_t[2] - rsp_t[1], 32'd6);
      check("b2b_latency", rsp_t[0] - hs_t[0], 32'd7);
    end

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK_IN); #1;
      REQ_VALID_IN = ($urandom_range(0, 2) == 0);
      REQ_RW_IN    = 1'($urandom);
      REQ_ADDR_IN  = 16'($urandom);
      REQ_WDATA_IN = 8'($urandom);
      CPU_P3_IN    = 8'($urandom);
    end
    @(posedge CLK_IN); #1;
    REQ_VALID_IN = 0;
    repeat (8) @(posedge CLK_IN);

    // Reset pulsed during the DATA phase of a write.
    #1;
    REQ_VALID_IN = 1; REQ_RW_IN = 0; REQ_ADDR_IN = 16'h3344; REQ_WDATA_IN = 8'h77;
    hs_now = 0;
    for (int i = 0; i < 20 && !hs_now; i++) begin
      @(negedge CLK_IN);
      hs_now = REQ_READY_OUT;
    end
    @(posedge CLK_IN); #1;
    REQ_VALID_IN = 0;
    seen_e = 0;
    for (int i = 0; i < 20 && !seen_e; i++) begin
      @(negedge CLK_IN);
      seen_e = E_OUT && !RW_OUT;
    end
    check("rst_reached_data", {31'b0, seen_e}, 32'd1);
    @(posedge CLK_IN); #3;
    RST_IN = 1;
    #1;
    check("rst_async_pins", {E_OUT, AS_OUT, RW_OUT, CPU_P3_IOM, REQ_READY_OUT, RSP_VALID_OUT, CPU_P4_OUT, CPU_P3_OUT},
          {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    @(posedge CLK_IN); #1;
    RST_IN = 0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_IN);
      quiet += int'(RSP_VALID_OUT);
    end
    check("rst_no_rsp", quiet, 32'd0);

`ifdef CPU_BUS_IRQ_SYNC_EN
    @(posedge CLK_IN); #1 IRQ_IN = 0;
    @(posedge CLK_IN); #1 IRQ_IN = 1;
    @(negedge CLK_IN); check("irq_pend_c1", {31'b0, IRQ_PEND_OUT}, 32'd0);
    @(negedge CLK_IN); check("irq_pend_c2", {31'b0, IRQ_PEND_OUT}, 32'd0);
    @(negedge CLK_IN); check("irq_pend_c3", {31'b0, IRQ_PEND_OUT}, 32'd1);
    repeat (2) @(negedge CLK_IN);
    check("irq_sticky", {31'b0, IRQ_PEND_OUT}, 32'd1);
    @(posedge CLK_IN); #1 IRQ_ACK_IN = 1;
    @(negedge CLK_IN); check("irq_ack_same", {31'b0, IRQ_PEND_OUT}, 32'd1);
    @(posedge CLK_IN); #1 IRQ_ACK_IN = 0;
    @(negedge CLK_IN); check("irq_ack_clear", {31'b0, IRQ_PEND_OUT}, 32'd0);
    @(posedge CLK_IN); #1 IRQ_IN = 0;
    repeat (4) @(posedge CLK_IN);
    #1 IRQ_ACK_IN = 1;
    @(posedge CLK_IN); #1 IRQ_ACK_IN = 0;
    @(negedge CLK_IN); check("irq_set_wins", {31'b0, IRQ_PEND_OUT}, 32'd1);
    IRQ_IN = 1;
    repeat (4) @(posedge CLK_IN);
    #1 IRQ_ACK_IN = 1;
    @(posedge CLK_IN); #1 IRQ_ACK_IN = 0;
    @(negedge CLK_IN); check("irq_final_clear", {31'b0, IRQ_PEND_OUT}, 32'd0);
`else
    @(posedge CLK_IN); #1 IRQ_IN = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_IN);
      check("irq_tied_low", {31'b0, IRQ_PEND_OUT}, 32'd0);
    end
    IRQ_IN = 1;
`endif

    repeat (2) @(posedge CLK_IN);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
